// File: rtl/motor_tx_pkg.sv
// Shared definitions for the motor telemetry frame scheduler.
//   state_t           : scheduler FSM states
//   FRAME_LEN_BASE    : SYNC + four motor bytes
//   FRAME_LEN_CSUM    : SYNC + four motor bytes + checksum
//   SYNC_BYTE_DEFAULT : default frame marker byte
//   idx_t             : byte index within a frame
package motor_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned FRAME_LEN_BASE    = 5;
    localparam int unsigned FRAME_LEN_CSUM    = 6;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned IDX_W             = 3;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic int unsigned frame_len(input bit csum_en);
        return csum_en ? FRAME_LEN_CSUM : FRAME_LEN_BASE;
    endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running period counter producing the frame start tick.
// Ports:
//   i_clk    : system clock
//   i_rst    : synchronous reset, active-high
//   i_enable : 1 lets the counter run, 0 holds it at 0 (no ticks)
//   o_tick   : combinational, high while count == PERIOD_CYCLES-1
module period_tick_gen #(
    parameter int unsigned PERIOD_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign o_tick = i_enable && (r_count == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_enable || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/motor_tx_scheduler.sv
// Periodic telemetry framer: SYNC, motor1..motor4 [, checksum] sent to the
// UART over a valid/ready byte handshake. Motor bytes are snapshotted at
// frame start so a frame never mixes old and new values.
// Optional feature macro: MOTOR_TX_CHECKSUM_EN appends (m1+m2+m3+m4) mod 256.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable          : runs the period counter
//   motor1..motor4  : live motor bytes
//   tx_ready        : UART accepts a byte this cycle
//   tx_valid/tx_data: byte offered to the UART
//   busy            : frame in progress
//   frame_done      : one-cycle pulse after the last byte is accepted
//   overrun         : sticky, a tick arrived while busy
module motor_tx_scheduler
    import motor_tx_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] motor1,
    input  logic [7:0] motor2,
    input  logic [7:0] motor3,
    input  logic [7:0] motor4,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

`ifdef MOTOR_TX_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam idx_t LAST_IDX = idx_t'(frame_len(CSUM_EN) - 1);

    state_t          r_state;
    idx_t            r_idx;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_overrun;
    logic [3:0][7:0] r_snap;

    state_t     w_state_n;
    idx_t       w_idx_n;
    logic [7:0] w_data_n;
    logic       w_valid_n;
    logic       w_busy_n;
    logic       w_done_n;
    logic       w_overrun_n;
    logic       w_capture;
    logic       w_tick;
    logic       w_accept;
    idx_t       w_next_idx;
    logic [7:0] w_next_byte;

    period_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_enable(enable),
        .o_tick  (w_tick)
    );

`ifdef MOTOR_TX_CHECKSUM_EN
    logic [7:0] w_csum;
    assign w_csum = r_snap[0] + r_snap[1] + r_snap[2] + r_snap[3];
`endif

    assign w_accept = r_valid && tx_ready;

    // Byte that follows the current one; always sourced from the snapshot.
    always_comb begin
        w_next_idx  = r_idx + idx_t'(1);
        w_next_byte = '0;
        case (w_next_idx)
            idx_t'(1): w_next_byte = r_snap[0];
            idx_t'(2): w_next_byte = r_snap[1];
            idx_t'(3): w_next_byte = r_snap[2];
            idx_t'(4): w_next_byte = r_snap[3];
`ifdef MOTOR_TX_CHECKSUM_EN
            idx_t'(5): w_next_byte = w_csum;
`endif
            default:   w_next_byte = '0;
        endcase
    end

    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_data_n    = r_data;
        w_valid_n   = r_valid;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;
        w_capture   = 1'b0;
        // busy is still 1 on the edge accepting the last byte, so a tick on
        // that edge also counts as an overrun.
        w_overrun_n = r_overrun | (w_tick & r_busy);

        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_capture = 1'b1;
                    w_data_n  = SYNC_BYTE;
                    w_valid_n = 1'b1;
                    w_busy_n  = 1'b1;
                    w_idx_n   = '0;
                    w_state_n = SEND;
                end
            end
            SEND: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_valid_n = 1'b0;
                        w_data_n  = '0;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                        w_idx_n   = '0;
                        w_state_n = IDLE;
                    end else begin
                        w_idx_n  = w_next_idx;
                        w_data_n = w_next_byte;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_snap    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_overrun <= w_overrun_n;
            if (w_capture) begin
                r_snap <= {motor4, motor3, motor2, motor1};
            end
        end
    end

    assign tx_valid   = r_valid;
    assign tx_data    = r_data;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_motor_tx_scheduler.sv
// Scoreboard bench for motor_tx_scheduler (PERIOD_CYCLES=20).
// Honours MOTOR_TX_CHECKSUM_EN to match the build of the design.
module tb_motor_tx_scheduler;

    localparam int P = 20;
`ifdef MOTOR_TX_CHECKSUM_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 5;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] motor1 = 8'h10;
    logic [7:0] motor2 = 8'h20;
    logic [7:0] motor3 = 8'h30;
    logic [7:0] motor4 = 8'h40;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    motor_tx_scheduler #(
        .PERIOD_CYCLES(P),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .motor1    (motor1),
        .motor2    (motor2),
        .motor3    (motor3),
        .motor4    (motor4),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         last;
    } sb_t;

    sb_t        q[$];
    int         starts[$];
    int         dones[$];
    int         cyc = 0;
    int         cnt = 0;
    int         frames_done = 0;
    int         nacc = 0;
    bit         mbusy = 0;
    bit         exp_ovr = 0;
    bit         exp_done = 0;
    bit         prev_valid = 0;
    logic [7:0] acc[6];
    logic [7:0] done_bytes[6];

    // Reference model + monitor. Inputs change only just after posedge, so
    // values seen here are what the DUT samples at the next posedge.
    always @(negedge clk) begin
        bit         tick;
        logic [7:0] cs;
        cyc++;
        if (rst) begin
            q.delete();
            cnt = 0; mbusy = 0; exp_ovr = 0; exp_done = 0;
            nacc = 0; prev_valid = 0;
        end else begin
            check_eq("busy", 32'(busy), 32'(mbusy));
            check_eq("tx_valid", 32'(tx_valid), 32'(mbusy));
            check_eq("overrun", 32'(overrun), 32'(exp_ovr));
            if (frame_done || exp_done)
                check_eq("frame_done", 32'(frame_done), 32'(exp_done));
            if (frame_done) dones.push_back(cyc);
            if (tx_valid) begin
                check_eq("sb_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) check_eq("tx_data", 32'(tx_data), 32'(q[0].data));
            end else if (prev_valid) begin
                check_eq("tx_data_idle", 32'(tx_data), 32'd0);
            end
            if (tx_valid && !prev_valid) starts.push_back(cyc);
            prev_valid = tx_valid;
            exp_done = 0;

            tick = enable && (cnt == P - 1);
            if (tick) begin
                if (mbusy) begin
                    exp_ovr = 1;
                end else begin
                    cs = motor1 + motor2 + motor3 + motor4;
                    q.push_back('{8'hA5, 1'b0});
                    q.push_back('{motor1, 1'b0});
                    q.push_back('{motor2, 1'b0});
                    q.push_back('{motor3, 1'b0});
`ifdef MOTOR_TX_CHECKSUM_EN
                    q.push_back('{motor4, 1'b0});
                    q.push_back('{cs, 1'b1});
`else
                    q.push_back('{motor4, 1'b1});
                    cs = 8'h00;
`endif
                    mbusy = 1;
                end
            end

            if (tx_valid && tx_ready && q.size() > 0) begin
                sb_t e;
                e = q.pop_front();
                if (nacc < 6) acc[nacc] = tx_data;
                nacc++;
                if (e.last) begin
                    mbusy = 0;
                    exp_done = 1;
                    frames_done++;
                    done_bytes = acc;
                    nacc = 0;
                end
            end

            if (!enable || cnt == P - 1) cnt = 0;
            else cnt++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (frames_done >= target) return;
        end
        check_eq("wait_frames", 32'(frames_done), 32'(target));
    endtask

    task automatic wait_start(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (starts.size() >= target) return;
        end
        check_eq("wait_start", 32'(starts.size()), 32'(target));
    endtask

    task automatic check_frame(input string tag, input logic [7:0] m1, input logic [7:0] cs);
        check_eq({tag, "_b0"}, 32'(done_bytes[0]), 32'h A5);
        check_eq({tag, "_b1"}, 32'(done_bytes[1]), 32'(m1));
        check_eq({tag, "_b2"}, 32'(done_bytes[2]), 32'h20);
        check_eq({tag, "_b3"}, 32'(done_bytes[3]), 32'h30);
        check_eq({tag, "_b4"}, 32'(done_bytes[4]), 32'h40);
`ifdef MOTOR_TX_CHECKSUM_EN
        check_eq({tag, "_cs"}, 32'(done_bytes[5]), 32'(cs));
`else
        check_eq({tag, "_cs_unused"}, 32'(cs != 8'h00), 32'd1);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int r0;
        int s0;
        int f0;

        // Reset and nominal back-to-back frames
        repeat (3) step();
        rst = 1'b0; enable = 1'b1;
        @(negedge clk); #1;
        r0 = cyc;
        check_reset_outputs("rst_init");
        wait_frames(1, 60);
        check_frame("f1", 8'h10, 8'hA0);
        if (starts.size() >= 1 && dones.size() >= 1) begin
            check_eq("first_start_lat", 32'(starts[0] - r0), 32'(P));
            check_eq("done_lat", 32'(dones[0] - starts[0]), 32'(FLEN));
        end
        wait_frames(2, 60);
        if (starts.size() >= 2) check_eq("period", 32'(starts[1] - starts[0]), 32'(P));

        // Stalling UART: 1,0,0 repeating
        f0 = frames_done;
        for (int i = 0; i < 200 && frames_done < f0 + 1; i++) begin
            step();
            tx_ready = ((i % 3) == 0);
        end
        step();
        tx_ready = 1'b1;
        check_eq("stall_frames", 32'(frames_done), 32'(f0 + 1));
        check_frame("stall", 8'h10, 8'hA0);

        // Motor change right after SYNC is accepted
        s0 = starts.size();
        f0 = frames_done;
        wait_start(s0 + 1, 60);
        step();
        motor1 = 8'h99;
        wait_frames(f0 + 1, 60);
        check_frame("snap_old", 8'h10, 8'hA0);
        wait_frames(f0 + 2, 60);
        check_frame("snap_new", 8'h99, 8'h29);

        // Long stall across a tick
        s0 = starts.size();
        f0 = frames_done;
        wait_start(s0 + 1, 60);
        step();
        tx_ready = 1'b0;
        repeat (30) step();
        check_eq("ovr_set", 32'(overrun), 32'd1);
        check_eq("ovr_no_new_start", 32'(starts.size()), 32'(s0 + 1));
        check_eq("ovr_frame_pending", 32'(frames_done), 32'(f0));
        tx_ready = 1'b1;
        wait_frames(f0 + 1, 40);
        repeat (25) step();
        check_eq("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame after byte 2
        s0 = starts.size();
        wait_start(s0 + 1, 60);
        for (int i = 0; i < 20 && nacc < 3; i++) begin
            @(negedge clk); #1;
        end
        check_eq("mid_nacc", 32'(nacc), 32'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk); #1;
        r0 = cyc;
        check_reset_outputs("rst_mid");
        s0 = starts.size();
        f0 = frames_done;
        wait_start(s0 + 1, 60);
        if (starts.size() > s0) check_eq("rst_restart_lat", 32'(starts[s0] - r0), 32'(P));
        wait_frames(f0 + 1, 40);
        check_frame("post_rst", 8'h99, 8'h29);

        // enable dropped mid-frame: frame completes, no further frames
        s0 = starts.size();
        f0 = frames_done;
        wait_start(s0 + 1, 60);
        step();
        enable = 1'b0;
        wait_frames(f0 + 1, 40);
        repeat (50) step();
        check_eq("en_off_frames", 32'(frames_done), 32'(f0 + 1));
        check_eq("en_off_starts", 32'(starts.size()), 32'(s0 + 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
